// File: rtl/ex_mdu_ctrl.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Runs a 32-step shift-add multiply or restoring divide and stalls the pipeline while busy.
module ex_mdu_ctrl #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] id_ex_reg_op_a_i,
    input  logic [XLEN-1:0] id_ex_reg_op_b_i,
    input  logic [2:0]      id_ex_reg_mdu_op_i,
    input  logic            id_ex_reg_mdu_req_i,
    input  logic [4:0]      id_ex_reg_reg_waddr_i,
    input  logic            flush_i,
    output logic            mdu_stall_o,
    output logic            mdu_valid_o,
    output logic [XLEN-1:0] mdu_op_c_o,
    output logic [4:0]      mdu_reg_waddr_o,
    output logic            mdu_reg_we_o
);

    // state | meaning
    // IDLE  | wait for a request
    // BUSY  | one multiply/divide step per cycle
    // DONE  | result presented for one cycle
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [4:0]      CNT_LAST = 5'(ITER - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [4:0]          waddr_q, cnt_q, waddr_out_q;
    logic [XLEN-1:0]     a_abs_q, b_abs_q, result_q;
    logic                neg_q, rem_neg_q;
    logic [2*XLEN-1:0]   acc_q, acc_step, prod;

    logic                a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]     a_abs, b_abs, fixed_res, final_res, quot, rem, sub;
    logic [XLEN:0]       trial;
    logic                load, fast, finish;

    always_comb begin
        a_signed  = id_ex_reg_mdu_op_i[2] ? ~id_ex_reg_mdu_op_i[0]
                                          : (id_ex_reg_mdu_op_i[1:0] != 2'b11);
        b_signed  = id_ex_reg_mdu_op_i[2] ? ~id_ex_reg_mdu_op_i[0] : ~id_ex_reg_mdu_op_i[1];
        a_neg     = a_signed & id_ex_reg_op_a_i[XLEN-1];
        b_neg     = b_signed & id_ex_reg_op_b_i[XLEN-1];
        a_abs     = a_neg ? -id_ex_reg_op_a_i : id_ex_reg_op_a_i;
        b_abs     = b_neg ? -id_ex_reg_op_b_i : id_ex_reg_op_b_i;
        div_zero  = id_ex_reg_mdu_op_i[2] & (id_ex_reg_op_b_i == '0);
        div_ovf   = id_ex_reg_mdu_op_i[2] & ~id_ex_reg_mdu_op_i[0]
                    & (id_ex_reg_op_a_i == MIN_NEG) & (id_ex_reg_op_b_i == '1);
        if (div_zero)
            fixed_res = id_ex_reg_mdu_op_i[1] ? id_ex_reg_op_a_i : '1;
        else
            fixed_res = id_ex_reg_mdu_op_i[1] ? '0 : MIN_NEG;
    end

    // Divide keeps {remainder, dividend/quotient} in the same accumulator.
    always_comb begin
        trial    = '0;
        sub      = '0;
        acc_step = acc_q;
        if (op_q[2]) begin
            trial = acc_q[2*XLEN-1:XLEN-1];
            sub   = trial[XLEN-1:0] - b_abs_q;
            if (trial >= {1'b0, b_abs_q})
                acc_step = {sub, acc_q[XLEN-2:0], 1'b1};
            else
                acc_step = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else if (b_abs_q[cnt_q]) begin
            acc_step = acc_q + ({{XLEN{1'b0}}, a_abs_q} << cnt_q);
        end
    end

    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        quot = acc_step[XLEN-1:0];
        rem  = acc_step[2*XLEN-1:XLEN];
        if (op_q[2])
            final_res = op_q[1] ? (rem_neg_q ? -rem : rem) : (neg_q ? -quot : quot);
        else
            final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        fast    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (id_ex_reg_mdu_req_i && !flush_i) begin
                    load = 1'b1;
                    if (div_zero || div_ovf) begin
                        fast    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (flush_i || !id_ex_reg_mdu_req_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            waddr_q     <= '0;
            cnt_q       <= '0;
            a_abs_q     <= '0;
            b_abs_q     <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            waddr_out_q <= '0;
        end else if (load) begin
            op_q      <= id_ex_reg_mdu_op_i;
            waddr_q   <= id_ex_reg_reg_waddr_i;
            cnt_q     <= '0;
            a_abs_q   <= a_abs;
            b_abs_q   <= b_abs;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            acc_q     <= id_ex_reg_mdu_op_i[2] ? {{XLEN{1'b0}}, a_abs} : '0;
            if (fast) begin
                result_q    <= fixed_res;
                waddr_out_q <= id_ex_reg_reg_waddr_i;
            end
        end else if (state_q == BUSY) begin
            acc_q <= acc_step;
            if (cnt_q != CNT_LAST)
                cnt_q <= cnt_q + 5'd1;
            if (finish) begin
                result_q    <= final_res;
                waddr_out_q <= waddr_q;
            end
        end
    end

    assign mdu_stall_o     = id_ex_reg_mdu_req_i & (state_q != DONE) & ~flush_i;
    assign mdu_valid_o     = (state_q == DONE);
    assign mdu_reg_we_o    = mdu_valid_o;
    assign mdu_op_c_o      = result_q;
    assign mdu_reg_waddr_o = waddr_out_q;

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Self-checking bench for ex_mdu_ctrl: directed vectors, random ops against an
// arithmetic reference model, flush/kill/reset aborts and back-to-back requests.
module tb_ex_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] op_a, op_b;
    logic [2:0]  mdu_op;
    logic        req;
    logic [4:0]  waddr;
    logic        flush;
    logic        stall, valid, we;
    logic [31:0] op_c;
    logic [4:0]  waddr_o;

    int checks   = 0;
    int failures = 0;

    ex_mdu_ctrl #(.XLEN(32), .ITER(32)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .id_ex_reg_op_a_i     (op_a),
        .id_ex_reg_op_b_i     (op_b),
        .id_ex_reg_mdu_op_i   (mdu_op),
        .id_ex_reg_mdu_req_i  (req),
        .id_ex_reg_reg_waddr_i(waddr),
        .flush_i              (flush),
        .mdu_stall_o          (stall),
        .mdu_valid_o          (valid),
        .mdu_op_c_o           (op_c),
        .mdu_reg_waddr_o      (waddr_o),
        .mdu_reg_we_o         (we)
    );

    always #5 clk = ~clk;

    // RV32M result computed with plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int     sa32, sb32;
        logic   ovf;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ua   = longint'({32'b0, a});
        ub   = longint'({32'b0, b});
        sa32 = $signed(a);
        sb32 = $signed(b);
        ovf  = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        p    = 0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'(sa32 / sb32);
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa32 % sb32);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 1;
        return 33;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] w);
        mdu_op = op;
        op_a   = a;
        op_b   = b;
        waddr  = w;
        req    = 1'b1;
    endtask

    // Called just after the negedge that starts T0; returns at the sample point of the valid cycle.
    task automatic wait_result(output int lat, output logic [31:0] res, output logic [4:0] wa,
                               output logic we_v, output logic stall_v, output int stall_low);
        lat = -1; res = '0; wa = '0; we_v = 1'b0; stall_v = 1'b1; stall_low = 0;
        #1;
        if (stall !== 1'b1) stall_low++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                lat = k; res = op_c; wa = waddr_o; we_v = we; stall_v = stall;
                break;
            end
            if (stall !== 1'b1) stall_low++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b0; flush = 1'b0;
        op_a = '0; op_b = '0; mdu_op = '0; waddr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b0 || we !== 1'b0 || op_c !== 32'h0 || waddr_o !== 5'h0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs valid=%b we=%b op_c=%h waddr=%0d stall=%b want all 0",
                     valid, we, op_c, waddr_o, stall);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_basic;
        int lat, sl; logic [31:0] r; logic [4:0] wa; logic wv, sv;
        issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
        wait_result(lat, r, wa, wv, sv, sl);
        req = 1'b0;
        checks++;
        if (lat !== 33 || r !== 32'hFFFFFFEB || wa !== 5'd5 || wv !== 1'b1 || sv !== 1'b0 || sl !== 0) begin
            failures++;
            $display("FAIL mul_basic lat=%0d res=%h wa=%0d we=%b stall=%b stall_lows=%0d want 33 ffffffeb 5 1 0 0",
                     lat, r, wa, wv, sv, sl);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || we !== 1'b0) begin
            failures++;
            $display("FAIL mul_valid_t34 valid=%b we=%b want 0", valid, we);
        end
    endtask

    typedef struct {logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; int lat;} vec_t;

    task automatic test_directed;
        vec_t v[11];
        int lat, sl; logic [31:0] r; logic [4:0] wa; logic wv, sv;
        v[0]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        v[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
        v[2]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33};
        v[3]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
        v[4]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
        v[5]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
        v[6]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
        v[7]  = '{3'd5, 32'h00001234, 32'h0,        32'hFFFFFFFF, 1};
        v[8]  = '{3'd6, 32'h00001234, 32'h0,        32'h00001234, 1};
        v[9]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        v[10] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        for (int i = 0; i < 11; i++) begin
            issue(v[i].op, v[i].a, v[i].b, 5'(i + 1));
            wait_result(lat, r, wa, wv, sv, sl);
            req = 1'b0;
            checks++;
            if (lat !== v[i].lat || r !== v[i].exp || wa !== 5'(i + 1) || wv !== 1'b1 || sl !== 0) begin
                failures++;
                $display("FAIL directed_%0d lat=%0d res=%h wa=%0d we=%b stall_lows=%0d want %0d %h %0d 1 0",
                         i, lat, r, wa, wv, sl, v[i].lat, v[i].exp, i + 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        int lat, sl, xl; logic [31:0] r, a, b, xr; logic [4:0] wa, w; logic wv, sv; logic [2:0] op;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = 32'($urandom_range(0, 300)) - 32'd150; b = 32'($urandom_range(0, 20)) - 32'd10; end
                default: ;
            endcase
            w  = 5'($urandom_range(0, 31));
            xr = model(op, a, b);
            xl = model_lat(op, a, b);
            issue(op, a, b, w);
            wait_result(lat, r, wa, wv, sv, sl);
            req = 1'b0;
            checks++;
            if (lat !== xl || r !== xr || wa !== w || sv !== 1'b0 || sl !== 0) begin
                failures++;
                $display("FAIL random_%0d op=%0d a=%h b=%h lat=%0d res=%h wa=%0d want lat=%0d res=%h wa=%0d",
                         i, op, a, b, lat, r, wa, xl, xr, w);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush;
        int pulses = 0;
        logic stall_f;
        issue(3'd0, 32'd123, 32'd456, 5'd3);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1 stall_f = stall;
        @(negedge clk);
        flush = 1'b0;
        req   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (valid === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (stall_f !== 1'b0 || pulses != 0) begin
            failures++;
            $display("FAIL flush stall=%b valid_pulses=%0d want 0 0", stall_f, pulses);
        end
    endtask

    task automatic test_req_kill;
        int pulses = 0;
        issue(3'd5, 32'd1000, 32'd3, 5'd4);
        repeat (15) @(negedge clk);
        req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL req_kill valid_pulses=%0d want 0", pulses);
        end
    endtask

    task automatic test_reset_mid_op;
        int lat, sl; logic [31:0] r; logic [4:0] wa; logic wv, sv;
        issue(3'd0, 32'h1234, 32'h10, 5'd7);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || we !== 1'b0 || op_c !== 32'h0 || waddr_o !== 5'h0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_op valid=%b we=%b op_c=%h waddr=%0d stall=%b want all 0",
                     valid, we, op_c, waddr_o, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'd0, 32'd3, 32'd4, 5'd9);
        wait_result(lat, r, wa, wv, sv, sl);
        req = 1'b0;
        checks++;
        if (lat !== 33 || r !== 32'd12 || wa !== 5'd9) begin
            failures++;
            $display("FAIL mul_after_reset lat=%0d res=%h wa=%0d want 33 0000000c 9", lat, r, wa);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, sl1, sl2; logic [31:0] r1, r2; logic [4:0] wa1, wa2; logic wv, sv;
        logic stall_t34, valid_t34;
        issue(3'd0, 32'd2, 32'd3, 5'd1);
        wait_result(lat1, r1, wa1, wv, sv, sl1);
        issue(3'd0, 32'd5, 32'd5, 5'd2);
        @(negedge clk);
        #1 stall_t34 = stall;
        valid_t34 = valid;
        wait_result(lat2, r2, wa2, wv, sv, sl2);
        req = 1'b0;
        checks++;
        if (lat1 !== 33 || r1 !== 32'd6 || wa1 !== 5'd1 || sl1 !== 0) begin
            failures++;
            $display("FAIL b2b_first lat=%0d res=%h wa=%0d stall_lows=%0d want 33 6 1 0", lat1, r1, wa1, sl1);
        end
        checks++;
        if (lat2 !== 33 || r2 !== 32'd25 || wa2 !== 5'd2 || sl2 !== 0 || stall_t34 !== 1'b1 || valid_t34 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second lat=%0d(abs %0d) res=%h wa=%0d stall_lows=%0d stall_t34=%b valid_t34=%b want 33(67) 25 2 0 1 0",
                     lat2, 34 + lat2, r2, wa2, sl2, stall_t34, valid_t34);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_mul_basic;
        test_directed;
        test_random;
        test_flush;
        test_req_kill;
        test_reset_mid_op;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mdu_ctrl.md
# ex_mdu_ctrl

Iterative multiply/divide sequencer beside the single-cycle ALU in the EX stage. It takes RV32M operations from the ID/EX register and runs a 32-step shift-add multiply or restoring divide. While it works, it holds the pipeline with a stall. When the result is ready it presents it for one cycle, with a write address and write enable, to the EX/MEM register.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.
- `ITER`, 32, iteration count; must equal `XLEN`.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `id_ex_reg_op_a_i`  input  32  rs1 value (multiplicand / dividend).
- `id_ex_reg_op_b_i`  input  32  rs2 value (multiplier / divisor).
- `id_ex_reg_mdu_op_i`  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `id_ex_reg_mdu_req_i`  input  1  the instruction in ID/EX is an M-extension operation.
- `id_ex_reg_reg_waddr_i`  input  5  destination register.
- `flush_i`  input  1  synchronous abort of the current operation.
- `mdu_stall_o`  output  1  hold the IF/ID/EX pipeline registers.
- `mdu_valid_o`  output  1  result valid, one-cycle pulse.
- `mdu_op_c_o`  output  32  result.
- `mdu_reg_waddr_o`  output  5  captured destination register.
- `mdu_reg_we_o`  output  1  equals `mdu_valid_o`.

## Operation
- States:
  - IDLE: wait for a request.
  - BUSY: iterate.
  - DONE: present the result.
- IDLE with `req=1`:
  - Capture the op, waddr, |a|, |b| and the result sign.
  - Divide by zero or signed overflow (0x80000000 / -1) goes straight to DONE with the fixed result.
  - Otherwise go to BUSY with the counter at 0.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Multiply, BUSY: 64-bit accumulator. Each step adds |a|<<i when b[i]=1. Results:
  - MUL takes the low word.
  - MULH, MULHSU and MULHU take the high word after two's-complement negation of the 64-bit product when the sign is negative.
- Divide, BUSY: restoring divide of |a| by |b|, one quotient bit per cycle, MSB first.
  - Quotient is negated if sign(a)≠sign(b).
  - Remainder takes the sign of a.
- Fixed results:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = a.
  - Overflow: quotient 0x80000000, remainder 0.
- BUSY moves to DONE when the counter reaches 31. The counter is 5 bits and does not wrap past 31.
- DONE always moves to IDLE; the next request is accepted in IDLE.
- `flush_i=1` in any state moves to IDLE at the next edge. No valid pulse is produced for the aborted operation. `flush_i` overrides the BUSY→DONE transition on the same edge.
- `req=0` while BUSY (pipeline killed upstream) is treated as a flush.

## Timing
- `mdu_stall_o = req & ~(state==DONE) & ~flush_i`, combinational. It is high in the request cycle, so the instruction stays in ID/EX.
- Normal latency: request in IDLE at T0, BUSY for T1..T32, DONE at T33.
  - `mdu_valid_o`/`mdu_reg_we_o` are high in T33 only.
  - The stall is low in T33, so the pipeline advances at the end of T33.
- Fast path (divide by zero, overflow): DONE at T1.
- Back-to-back requests: the next operation is accepted at T34, leaving one idle cycle between them.
- `mdu_op_c_o`/`mdu_reg_waddr_o` are registered. They hold their last value outside DONE; the consumer qualifies with valid.
- Reset (async, also mid-operation):
  - State IDLE, counter 0, accumulators 0.
  - `mdu_stall_o`=0 while `req`=0.
  - `mdu_valid_o`=0, `mdu_reg_we_o`=0, `mdu_op_c_o`=0, `mdu_reg_waddr_o`=0.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3), waddr=5 -> stall T0..T32; at T33 `mdu_valid_o`=1, `mdu_op_c_o`=0xFFFFFFEB, `mdu_reg_waddr_o`=5; valid low at T34.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU a=0x1234, b=0 -> valid at T1, 0xFFFFFFFF; REM a=0x1234, b=0 -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T1; REM same -> 0.
- `flush_i` at BUSY cycle 10 -> IDLE next edge, no valid pulse, stall low. `rst_n` low at BUSY cycle 20 -> all outputs 0 immediately. A new MUL 3×4 then returns 12 at its T33.
- Two consecutive MUL requests (2×3, then 5×5) -> valid pulses at T33 and T67 with 6 and 25; stall never low in T0 of either.
